// File: rtl/key_expand_inv_if.sv
// Control/read bundle for the inverse AES-128 key expander: the round-10 key load
// handshake plus the indexed round-key read port.
interface key_expand_inv_if;
   logic        start;
   logic [31:0] last_key;
   logic [1:0]  r_index;
   logic [3:0]  round_key_num;
   logic [31:0] round_key;
   logic        busy;
   logic        done;

   modport master (
      output start, last_key, r_index, round_key_num,
      input  round_key, busy, done
   );

   modport slave (
      input  start, last_key, r_index, round_key_num,
      output round_key, busy, done
   );
endinterface

// File: rtl/key_expand_inv.sv
// Inverse AES-128 key schedule: loads round key 10 and walks back to round key 0,
// one round per cycle, keeping all 11 keys readable a word at a time.
module key_expand_inv (
   input logic           clk,
   input logic           reset,
   key_expand_inv_if.slave kif
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] EXPAND = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   // Forward S-box, entry 0x00 in the most-significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   logic [1:0]   state;
   logic [1:0]   load_count;
   logic [3:0]   rnd;
   logic [127:0] work;
   logic [127:0] round_keys [0:10];

   logic [31:0]  b0, b1, b2, b3;
   logic [127:0] prev_key;

   // b3 must be formed first: it feeds RotWord/SubWord for b0.
   always_comb begin
      b3       = work[31:0]  ^ work[63:32];
      b2       = work[63:32] ^ work[95:64];
      b1       = work[95:64] ^ work[127:96];
      b0       = work[127:96] ^ sub_word({b3[23:0], b3[31:24]}) ^ {rcon(rnd), 24'h0};
      prev_key = {b0, b1, b2, b3};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         load_count <= 2'd0;
         rnd        <= 4'd0;
         work       <= '0;
         for (int i = 0; i < 11; i++) round_keys[i] <= '0;
      end else if (kif.start) begin
         state      <= LOAD;
         load_count <= 2'd0;
      end else begin
         case (state)
            LOAD: begin
               round_keys[10][{~load_count, 5'b00000} +: 32] <= kif.last_key;
               work       <= {work[95:0], kif.last_key};
               load_count <= load_count + 2'd1;
               if (load_count == 2'd3) begin
                  state <= EXPAND;
                  rnd   <= 4'd10;
               end
            end
            EXPAND: begin
               round_keys[rnd - 4'd1] <= prev_key;
               work <= prev_key;
               rnd  <= rnd - 4'd1;
               if (rnd == 4'd1) state <= DONE;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      kif.round_key = 32'h0;
      if (kif.round_key_num <= 4'd10)
         kif.round_key = round_keys[kif.round_key_num][{~kif.r_index, 5'b00000} +: 32];
   end

   assign kif.busy = (state == LOAD) || (state == EXPAND);
   assign kif.done = (state == DONE);
endmodule

// File: tb/tb_key_expand_inv.sv
// Directed bench for key_expand_inv: FIPS-197 vectors, reset, restart and back-to-back runs.
module tb_key_expand_inv;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   key_expand_inv_if kif ();

   key_expand_inv dut (
      .clk   (clk),
      .reset (reset),
      .kif   (kif.slave)
   );

   always #5 clk = ~clk;

   logic [31:0] fips_k10 [4] = '{32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};
   logic [31:0] fips_k0  [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
   logic [31:0] c1_k10   [4] = '{32'h13111d7f, 32'he3944a17, 32'hf307a78b, 32'h4d2b30c5};
   logic [31:0] c1_k0    [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [3:0] num, input logic [1:0] idx, output logic [31:0] val);
      kif.round_key_num = num;
      kif.r_index       = idx;
      #1;
      val = kif.round_key;
   endtask

   task automatic pulse_start();
      kif.start = 1'b1;
      tick();
      kif.start = 1'b0;
   endtask

   task automatic load_words(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
      kif.last_key = w0; tick();
      kif.last_key = w1; tick();
      kif.last_key = w2; tick();
      kif.last_key = w3; tick();
      kif.last_key = 32'hdeadbeef;
   endtask

   // Counts edges from the start edge (cycles already elapsed passed in) until done.
   task automatic wait_done(input int already, output int cyc);
      cyc = already;
      while (kif.done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   logic [31:0] v;
   int          cyc;

   initial begin
      reset = 1'b1;
      kif.start = 1'b0;
      kif.last_key = 32'h0;
      kif.r_index = 2'd0;
      kif.round_key_num = 4'd0;
      tick();
      tick();
      reset = 1'b0;
      #1;

      // Reset state
      chk("rst_done", {31'b0, kif.done}, 32'h0);
      chk("rst_busy", {31'b0, kif.busy}, 32'h0);
      for (int n = 0; n < 16; n++)
         for (int i = 0; i < 4; i++) begin
            rd(4'(n), 2'(i), v);
            chk($sformatf("rst_key_%0d_%0d", n, i), v, 32'h0);
         end

      // FIPS-197 run
      pulse_start();
      chk("fips_busy_after_start", {31'b0, kif.busy}, 32'h1);
      load_words(fips_k10[0], fips_k10[1], fips_k10[2], fips_k10[3]);
      chk("fips_busy_expand", {31'b0, kif.busy}, 32'h1);
      wait_done(4, cyc);
      chk("fips_done_latency", cyc, 32'd14);
      chk("fips_busy_done", {31'b0, kif.busy}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         rd(4'd0, 2'(i), v);
         chk($sformatf("fips_k0_w%0d", i), v, fips_k0[i]);
      end
      rd(4'd1, 2'd0, v);  chk("fips_k1_w0", v, 32'ha0fafe17);
      rd(4'd9, 2'd3, v);  chk("fips_k9_w3", v, 32'h575c006e);
      rd(4'd10, 2'd0, v); chk("fips_k10_w0", v, 32'hd014f9a8);
      rd(4'd12, 2'd0, v); chk("fips_k12", v, 32'h0);
      tick();
      chk("fips_done_held", {31'b0, kif.done}, 32'h1);

      // Reset at E8 of a run
      pulse_start();
      load_words(fips_k10[0], fips_k10[1], fips_k10[2], fips_k10[3]);
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("midrst_done", {31'b0, kif.done}, 32'h0);
      chk("midrst_busy", {31'b0, kif.busy}, 32'h0);
      rd(4'd0, 2'd0, v);  chk("midrst_k0", v, 32'h0);
      rd(4'd10, 2'd0, v); chk("midrst_k10", v, 32'h0);
      for (int i = 0; i < 10; i++) tick();
      chk("midrst_done_stays0", {31'b0, kif.done}, 32'h0);

      // Restart at E7
      pulse_start();
      load_words(fips_k10[0], fips_k10[1], fips_k10[2], fips_k10[3]);
      tick(); tick();
      pulse_start();
      load_words(fips_k10[0], fips_k10[1], fips_k10[2], fips_k10[3]);
      tick(); tick(); tick();
      chk("restart_no_early_done", {31'b0, kif.done}, 32'h0);
      wait_done(7, cyc);
      chk("restart_latency", cyc, 32'd14);
      for (int i = 0; i < 4; i++) begin
         rd(4'd0, 2'(i), v);
         chk($sformatf("restart_k0_w%0d", i), v, fips_k0[i]);
      end

      // Back-to-back run with the FIPS-197 C.1 key
      pulse_start();
      chk("b2b_done_drop", {31'b0, kif.done}, 32'h0);
      chk("b2b_busy", {31'b0, kif.busy}, 32'h1);
      load_words(c1_k10[0], c1_k10[1], c1_k10[2], c1_k10[3]);
      wait_done(4, cyc);
      chk("b2b_latency", cyc, 32'd14);
      for (int i = 0; i < 4; i++) begin
         rd(4'd0, 2'(i), v);
         chk($sformatf("b2b_k0_w%0d", i), v, c1_k0[i]);
      end
      rd(4'd10, 2'd3, v); chk("b2b_k10_w3", v, 32'h4d2b30c5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
